// File: rtl/uart_test_pkg.sv
// Shared types and sizing helpers for the PRBS byte sequencer.
package uart_test_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        PRESENT = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/prbs_deserializer.sv
// Collects WORD_W serial LFSR bits MSB-first and flags the cycle the word completes.
module prbs_deserializer
    import uart_test_pkg::*;
#(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en_i,
    input  logic              bit_i,
    output logic              word_complete_c,
    output logic [WORD_W-1:0] word_c
);

    localparam int unsigned BIT_CNT_W = cnt_width(WORD_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0]    sr_q, sr_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // The word includes the bit sampled on the completing edge.
    assign sr_d            = {sr_q[WORD_W-2:0], bit_i};
    assign word_c          = sr_d;
    assign word_complete_c = shift_en_i && (bit_cnt_q == LAST_BIT);

    always_comb begin
        bit_cnt_d = '0;
        if (shift_en_i && !word_complete_c) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            if (shift_en_i) begin
                sr_q <= sr_d;
            end
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/prbs_byte_sequencer.sv
// Bursts LFSR-generated bytes to a UART TX over valid/ready, with optional
// inter-byte gap, abort and completion status.
module prbs_byte_sequencer
    import uart_test_pkg::*;
#(
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              lfsr_data,
    output logic              lfsr_clk_en,
    output logic              tx_valid,
    output logic [WORD_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  byte_count
);

    localparam int unsigned GAP_CNT_W = cnt_width(GAP_CYCLES);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WORD_W-1:0]   tx_data_q, tx_data_d;
    logic                lfsr_en_q, tx_valid_q, busy_q, done_q;
    logic                word_complete_c;
    logic [WORD_W-1:0]   word_c;

    prbs_deserializer #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk             (clk),
        .rst             (rst),
        .shift_en_i      (state_q == SHIFT),
        .bit_i           (lfsr_data),
        .word_complete_c (word_complete_c),
        .word_c          (word_c)
    );

    // Next-state: abort beats everything, including start and a live handshake.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_data_d  = tx_data_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d      = burst_len;
                        byte_cnt_d = '0;
                        state_d    = (burst_len == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (word_complete_c) begin
                        tx_data_d = word_c;
                        state_d   = PRESENT;
                    end
                end
                PRESENT: begin
                    if (tx_ready) begin
                        byte_cnt_d = byte_cnt_q + LEN_W'(1);
                        if (byte_cnt_d == len_q) begin
                            state_d = DONE;
                        end else if (GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = SHIFT;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they align with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_data_q  <= '0;
            lfsr_en_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_data_q  <= tx_data_d;
            lfsr_en_q  <= (state_d == SHIFT);
            tx_valid_q <= (state_d == PRESENT);
            busy_q     <= (state_d == SHIFT) || (state_d == PRESENT) || (state_d == GAP);
            done_q     <= (state_q == DONE) && !abort;
        end
    end

    assign lfsr_clk_en = lfsr_en_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign byte_count  = byte_cnt_q;

endmodule

// File: tb/tb_prbs_byte_sequencer.sv
// Scoreboard bench: stimulus predicts words from the bit source, a negedge monitor checks them.
module tb_prbs_byte_sequencer;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned GAP    = 4;
    localparam int unsigned NBITS  = 4096;

    logic              clk = 1'b0;
    logic              rst, start, abort, lfsr_data, lfsr_clk_en;
    logic              tx_valid, tx_ready, busy, done;
    logic [LEN_W-1:0]  burst_len, byte_count;
    logic [WORD_W-1:0] tx_data;

    int checks = 0;
    int failures = 0;

    // Bit source state (stands in for the external LFSR) and model state
    int unsigned src_mode;
    int unsigned step_cnt;
    int unsigned model_step;
    bit          prbs_bits [NBITS];
    bit          rdy_rand;

    logic [WORD_W-1:0] exp_q [$];
    logic [WORD_W-1:0] mon_exp, prev_data;
    int  acc_total = 0, acc_base = 0, cur_len = 0;
    int  done_total = 0, en_total = 0, gap_seen = 0, gap_cnt = 0;
    bit  prev_hold, gap_arm;

    prbs_byte_sequencer #(
        .WORD_W     (WORD_W),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .burst_len   (burst_len),
        .lfsr_data   (lfsr_data),
        .lfsr_clk_en (lfsr_clk_en),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              step_cnt <= 0;
        else if (lfsr_clk_en) step_cnt <= step_cnt + 1;
    end

    always_comb begin
        case (src_mode)
            0:       lfsr_data = 1'b1;
            1:       lfsr_data = ~step_cnt[0];
            default: lfsr_data = prbs_bits[step_cnt % NBITS];
        endcase
    end

    function automatic int unsigned model_bit(input int unsigned mode, input int unsigned idx);
        if (mode == 0) return 1;
        if (mode == 1) return (idx % 2 == 0) ? 1 : 0;
        return prbs_bits[idx % NBITS] ? 1 : 0;
    endfunction

    // First bit generated lands in the MSB.
    function automatic logic [WORD_W-1:0] exp_word(input int unsigned mode, input int unsigned base);
        int unsigned v;
        v = 0;
        for (int i = 0; i < WORD_W; i++) v += model_bit(mode, base + i) << (WORD_W - 1 - i);
        return WORD_W'(v);
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_burst(input int len, input int n_gen);
        cur_len  = len;
        acc_base = acc_total;
        for (int w = 0; w < n_gen; w++) begin
            exp_q.push_back(exp_word(src_mode, model_step));
            model_step += WORD_W;
        end
        burst_len = LEN_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 1;
        while (!tx_valid && lat < 300) begin
            tick();
            lat++;
        end
        chk(tx_valid, {name, "_valid_timeout"}, int'(tx_valid), 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || tx_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk(!busy && !tx_valid, {name, "_idle_timeout"}, int'(busy), 0);
        tick();
        tick();
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(lfsr_clk_en == 1'b0, {name, "_lfsr_clk_en"}, int'(lfsr_clk_en), 0);
        chk(tx_valid == 1'b0,    {name, "_tx_valid"},    int'(tx_valid), 0);
        chk(busy == 1'b0,        {name, "_busy"},        int'(busy), 0);
        chk(done == 1'b0,        {name, "_done"},        int'(done), 0);
        chk(tx_data == '0,       {name, "_tx_data"},     int'(tx_data), 0);
        chk(byte_count == '0,    {name, "_byte_count"},  int'(byte_count), 0);
    endtask

    // Accepts k-1 words, then aborts in the same cycle as the k-th handshake.
    task automatic run_abort(input int len, input int k, input string name);
        int d0, lat;
        d0 = done_total;
        rdy_rand = 1'b0;
        tx_ready = 1'b0;
        start_burst(len, k);
        for (int w = 1; w <= k; w++) begin
            wait_valid(name, lat);
            tx_ready = 1'b1;
            if (w == k) abort = 1'b1;
            tick();
            tx_ready = 1'b0;
            abort = 1'b0;
        end
        chk(tx_valid == 1'b0,    {name, "_tx_valid"},    int'(tx_valid), 0);
        chk(busy == 1'b0,        {name, "_busy"},        int'(busy), 0);
        chk(lfsr_clk_en == 1'b0, {name, "_lfsr_clk_en"}, int'(lfsr_clk_en), 0);
        chk(byte_count == LEN_W'(k - 1), {name, "_byte_count"}, int'(byte_count), k - 1);
        repeat (3) tick();
        chk(done_total == d0, {name, "_no_done"}, done_total - d0, 0);
    endtask

    // Monitor: pops the scoreboard whenever a presented word ends (handshake or abort).
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                gap_arm   = 1'b0;
                en_total  = 0;
            end else begin
                if (done) done_total++;
                if (lfsr_clk_en) en_total++;
                if (tx_valid) begin
                    chk(!lfsr_clk_en, "no_step_while_valid", int'(lfsr_clk_en), 0);
                    if (prev_hold) chk(tx_data == prev_data, "data_stable", int'(tx_data), int'(prev_data));
                    if (tx_ready || abort) begin
                        chk(exp_q.size() != 0, "word_expected", exp_q.size(), 1);
                        if (exp_q.size() != 0) begin
                            mon_exp = exp_q.pop_front();
                            chk(tx_data == mon_exp, "word", int'(tx_data), int'(mon_exp));
                        end
                        prev_hold = 1'b0;
                        if (!abort) begin
                            acc_total++;
                            if (acc_total - acc_base != cur_len) begin
                                gap_arm = 1'b1;
                                gap_cnt = 0;
                            end
                        end
                    end else begin
                        prev_hold = 1'b1;
                        prev_data = tx_data;
                    end
                end else begin
                    if (prev_hold) chk(tx_valid, "valid_held", int'(tx_valid), 1);
                    prev_hold = 1'b0;
                    if (gap_arm) begin
                        if (lfsr_clk_en) begin
                            chk(gap_cnt == GAP, "gap_len", gap_cnt, GAP);
                            gap_seen++;
                            gap_arm = 1'b0;
                        end else begin
                            gap_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int d0, e0, g0, lat, len, k;
        logic [7:0] x;
        rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        burst_len = '0; rdy_rand = 1'b0; src_mode = 0; model_step = 0;
        x = 8'hA5;
        for (int i = 0; i < NBITS; i++) begin
            prbs_bits[i] = x[7];
            x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        #2 rst = 1'b0;
        tick();

        // Constant ones, always ready
        src_mode = 0; tx_ready = 1'b1;
        d0 = done_total;
        start_burst(3, 3);
        wait_valid("ones", lat);
        chk(lat == 9, "ones_first_valid_latency", lat, 9);
        wait_idle("ones");
        chk(byte_count == 8'd3, "ones_byte_count", int'(byte_count), 3);
        chk(done_total - d0 == 1, "ones_done_pulses", done_total - d0, 1);
        chk(en_total == 24, "ones_lfsr_steps", en_total, 24);

        // Alternating bits; a start while busy must be ignored
        src_mode = 1;
        d0 = done_total;
        start_burst(2, 2);
        repeat (3) tick();
        burst_len = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("alt");
        chk(byte_count == 8'd2, "alt_byte_count", int'(byte_count), 2);
        chk(done_total - d0 == 1, "alt_done_pulses", done_total - d0, 1);

        // Backpressure for 20 cycles
        src_mode = 2; tx_ready = 1'b0;
        start_burst(1, 1);
        wait_valid("bp", lat);
        e0 = en_total;
        repeat (20) tick();
        chk(tx_valid == 1'b1, "bp_valid_held", int'(tx_valid), 1);
        chk(en_total == e0, "bp_no_lfsr_steps", en_total - e0, 0);
        tx_ready = 1'b1;
        tick();
        chk(tx_valid == 1'b0, "bp_valid_drop", int'(tx_valid), 0);
        wait_idle("bp");
        chk(byte_count == 8'd1, "bp_byte_count", int'(byte_count), 1);

        // Inter-byte gap, always ready
        g0 = gap_seen;
        start_burst(3, 3);
        wait_idle("gap");
        chk(gap_seen - g0 == 2, "gap_count", gap_seen - g0, 2);

        // Zero-length burst
        d0 = done_total;
        start_burst(0, 0);
        chk(done == 1'b0, "zero_done_early", int'(done), 0);
        tick();
        chk(done == 1'b1, "zero_done_pulse", int'(done), 1);
        tick();
        chk(done == 1'b0, "zero_done_single", int'(done), 0);
        chk(busy == 1'b0, "zero_busy", int'(busy), 0);
        chk(byte_count == 8'd0, "zero_byte_count", int'(byte_count), 0);

        // Abort on the handshake of word 2 of 5
        run_abort(5, 2, "abort");

        // start together with abort in IDLE
        burst_len = 8'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk(busy == 1'b0, "start_abort_busy", int'(busy), 0);
        tick();
        chk(lfsr_clk_en == 1'b0, "start_abort_lfsr", int'(lfsr_clk_en), 0);
        chk(en_total == model_step, "lfsr_steps_pre_reset", en_total, model_step);

        // Asynchronous reset in the middle of SHIFT
        tx_ready = 1'b1;
        d0 = done_total;
        start_burst(4, 4);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk_zero_outputs("midreset");
        exp_q.delete();
        model_step = 0;
        tick();
        #2 rst = 1'b0;
        repeat (3) tick();
        chk(done_total == d0, "midreset_no_done", done_total - d0, 0);

        // Randomized bursts
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(0, 5);
            src_mode = $urandom_range(0, 2);
            if (len > 0 && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, len);
                run_abort(len, k, "rnd_abort");
            end else begin
                d0 = done_total;
                rdy_rand = 1'b1;
                start_burst(len, len);
                wait_idle("rnd");
                rdy_rand = 1'b0;
                chk(byte_count == LEN_W'(len), "rnd_byte_count", int'(byte_count), len);
                chk(done_total - d0 == 1, "rnd_done_pulses", done_total - d0, 1);
            end
            chk(en_total == model_step, "rnd_lfsr_steps", en_total, model_step);
        end

        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_byte_sequencer.md
Name: prbs_byte_sequencer

Overview:
Controller that sequences the 8-bit LFSR bit generator (ports clk, rst, clk_en, data) to produce a burst of pseudo-random bytes for the UART transmit path. It gates the LFSR's clk_en, deserializes its serial output into bytes MSB-first, and presents each byte on a valid/ready handshake to the UART TX.
Runs one burst per start pulse, with an optional idle gap between bytes, plus abort and completion status.

Parameters:
WORD_W, 8, bits per generated word; number of LFSR steps per word.
LEN_W, 8, width of the burst_len input and the byte_count output.
GAP_CYCLES, 0, idle cycles inserted after each accepted byte before the next word is generated; 0 means no gap.

Ports:
clk  input  1  system clock; all logic rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a burst; ignored while busy=1.
abort  input  1  synchronous; terminates the burst.
burst_len  input  LEN_W  number of words in the burst; sampled on accepted start.
lfsr_data  input  1  serial bit from the LFSR data output.
lfsr_clk_en  output  1  step enable to the LFSR clk_en input.
tx_valid  output  1  tx_data holds a complete word.
tx_data  output  WORD_W  generated word.
tx_ready  input  1  UART TX accepts the word when tx_valid and tx_ready are both 1.
busy  output  1  high from the cycle after an accepted start until return to IDLE.
done  output  1  one-cycle pulse when a burst completes normally.
byte_count  output  LEN_W  number of words accepted in the current or last burst.

Behaviour:
- Reset (async assert): state=IDLE. lfsr_clk_en, tx_valid, busy and done are 0; tx_data, byte_count and the shift register are 0. Deassertion is synchronous to clk.
- States: IDLE, SHIFT, PRESENT, GAP, DONE.
- IDLE: on start=1, latch burst_len and clear byte_count.
  - If burst_len=0, go to DONE.
  - Otherwise go to SHIFT with bit counter=0.
- SHIFT: lfsr_clk_en=1 every cycle of this state, exactly WORD_W cycles.
  - Each cycle, sample lfsr_data (the value present before that step's edge).
  - Update sr <= {sr[WORD_W-2:0], lfsr_data}, so the first bit ends up in the MSB.
  - After the WORD_W-th sample, load tx_data from sr, set tx_valid=1 and go to PRESENT. Latency from start to first tx_valid is WORD_W+1 cycles.
- PRESENT: lfsr_clk_en=0. tx_valid and tx_data are held stable until the handshake.
  - On handshake, tx_valid drops the next cycle and byte_count increments.
  - If the new byte_count equals the latched length, go to DONE.
  - Else if GAP_CYCLES>0, go to GAP.
  - Else go to SHIFT. No back-to-back valid: at least WORD_W cycles separate words.
- GAP: lfsr_clk_en=0 for exactly GAP_CYCLES cycles, then go to SHIFT.
- DONE: done=1 for one cycle, busy=0 from this cycle, then go to IDLE. byte_count holds until the next accepted start.
- abort=1 in any non-IDLE state: next state is IDLE and tx_valid, lfsr_clk_en and busy go to 0.
  - done is not pulsed and byte_count keeps the accepted count.
  - abort has priority over a same-cycle handshake; that word is not counted.
  - Dropping tx_valid without a handshake is permitted only on abort.
- start coinciding with abort in IDLE: abort wins, start is ignored.
- The LFSR is never stepped outside SHIFT, so its sequence continues across bursts. The LFSR's own reset is the shared rst.
- byte_count wraps modulo 2^LEN_W. It cannot exceed burst_len, so no overflow handling is required.
- Reset mid-burst: immediate return to the reset values above, with no done pulse.

Decomposition:
- Package uart_test_pkg holds:
  - the state enum (IDLE, SHIFT, PRESENT, GAP, DONE);
  - localparam BIT_CNT_W = $clog2(WORD_W+1);
  - localparam GAP_CNT_W = $clog2(GAP_CYCLES+1), minimum 1.
- One natural sub-module, prbs_deserializer: the shift register plus bit counter, enabled by the SHIFT state and signalling word_complete.
- FSM, gap counter and byte counter stay in the top level.

Test Plan:
- Reset check: assert rst asynchronously mid-SHIFT -> all outputs 0 within the same cycle; done never pulses.
- Constant ones: lfsr_data tied to 1, burst_len=3, tx_ready always 1, GAP_CYCLES=0 -> three words of 0xFF, tx_valid first high 9 cycles after start, one done pulse, byte_count=3, lfsr_clk_en high for exactly 24 cycles.
- Alternating bits: the bench LFSR model toggles on each lfsr_clk_en starting at 1, burst_len=2 -> 0xAA then 0xAA; start pulses while busy are ignored.
- Backpressure: tx_ready held 0 for 20 cycles -> tx_valid and tx_data stable throughout; lfsr_clk_en stays 0; word accepted on the first ready cycle.
- Gap and zero length: GAP_CYCLES=4 -> exactly 4 idle cycles between handshake and the next lfsr_clk_en. Separately, burst_len=0 -> done pulses 2 cycles after start with no tx_valid.
- Abort: abort in the same cycle as a handshake on word 2 of 5 -> state IDLE next cycle, byte_count=1, no done pulse, tx_valid=0.
